// File: rtl/hazard_unit_if.sv
// Hazard-control bundle between the pipeline datapath and hazard_unit.
// The master side is the pipeline (decode/execute status in, latch controls
// out); the slave side is the hazard controller itself.
interface hazard_unit_if;
  // Decode-stage operand usage
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_md_read;

  // Execute-stage status
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        ex_md_start;
  logic        ex_branch_taken;

  // Memory system back-pressure
  logic        mem_stall;

  // Pipeline latch controls
  logic        pc_we;
  logic        ifid_we;
  logic        idex_we;
  logic        exmem_we;
  logic        memwb_we;
  logic        ifid_flush;
  logic        idex_flush;

  // Multiply/divide sequencing and statistics
  logic        md_busy;
  logic        md_done;
  logic [31:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_md_read,
    output ex_mem_read, ex_rt, ex_md_start, ex_branch_taken,
    output mem_stall,
    input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
    input  ifid_flush, idex_flush,
    input  md_busy, md_done, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_md_read,
    input  ex_mem_read, ex_rt, ex_md_start, ex_branch_taken,
    input  mem_stall,
    output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
    output ifid_flush, idex_flush,
    output md_busy, md_done, stall_cycles
  );
endinterface : hazard_unit_if

// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage MIPS pipeline.
// Produces write-enable and flush controls for the PC and the four pipeline
// latches, resolving (in priority order) memory stalls, taken-branch squashes,
// load-use hazards and HI/LO readers waiting on the multiply/divide unit.
// Also sequences the fixed-latency multiply/divide unit and counts stall cycles.
module hazard_unit #(
  parameter int unsigned MD_CYCLES = 32  // busy cycles per mult/div, >= 2
) (
  input  logic         clk,
  input  logic         rst,             // asynchronous, active-low
  hazard_unit_if.slave hif
);

  localparam int unsigned CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MD_BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_done_q, md_done_d;
  logic [31:0]      stall_cycles_q, stall_cycles_d;

  logic md_busy;
  logic load_use;
  logic md_hold;

  logic pc_we;
  logic ifid_we;
  logic idex_we;
  logic exmem_we;
  logic memwb_we;
  logic ifid_flush;
  logic idex_flush;

  assign md_busy = (state_q == S_MD_BUSY);

  // Hazard detection: a load in EX whose destination is read by ID, or an
  // HI/LO consumer in ID while the multiply/divide unit is still working.
  // Register zero is hard-wired, so a load targeting it never conflicts.
  always_comb begin
    load_use = hif.ex_mem_read && (hif.ex_rt != 5'd0) &&
               ((hif.id_use_rs && (hif.id_rs == hif.ex_rt)) ||
                (hif.id_use_rt && (hif.id_rt == hif.ex_rt)));
    md_hold  = md_busy && hif.id_md_read;
  end

  // Multiply/divide sequencer: next state, counter and done pulse.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A start under mem_stall is not accepted; the EX instruction is
        // frozen and will present the start again once the stall lifts.
        if (hif.ex_md_start && !hif.mem_stall) begin
          state_d = S_MD_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      S_MD_BUSY: begin
        // The unit runs on its own clock budget: mem_stall does not pause it,
        // and further starts are ignored until it returns to IDLE.
        if (cnt_q == '0) begin
          state_d   = S_IDLE;
          md_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pipeline latch controls, highest-priority condition first. While reset is
  // asserted everything is held off so no latch captures during reset.
  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    idex_we    = 1'b1;
    exmem_we   = 1'b1;
    memwb_we   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rst || hif.mem_stall) begin
      // Whole pipeline frozen
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else if (hif.ex_branch_taken) begin
      // Squash the two wrong-path instructions; the squashed ID instruction
      // therefore cannot request a stall.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use || md_hold) begin
      // Hold PC and IF/ID, inject a bubble into EX, let the older
      // instructions drain.
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Stall statistics: one count per cycle in which the PC does not advance.
  // Reset cycles are excluded by the reset branch of the register below.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_we) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  // State registers with asynchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge inputs, independent of statement order between blocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      md_done_q      <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      md_done_q      <= md_done_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Drive the bundle outputs.
  assign hif.pc_we        = pc_we;
  assign hif.ifid_we      = ifid_we;
  assign hif.idex_we      = idex_we;
  assign hif.exmem_we     = exmem_we;
  assign hif.memwb_we     = memwb_we;
  assign hif.ifid_flush   = ifid_flush;
  assign hif.idex_flush   = idex_flush;
  assign hif.md_busy      = md_busy;
  assign hif.md_done      = md_done_q;
  assign hif.stall_cycles = stall_cycles_q;

endmodule : hazard_unit

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: a priority table of control vectors,
// hand-written multi-cycle sequences and a randomized run, all compared
// against a cycle-level reference model of the hazard rules.
module tb_hazard_unit;

  localparam int MD_CYCLES = 4;

  typedef struct {
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_md_read;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       ex_md_start;
    logic       ex_branch_taken;
    logic       mem_stall;
  } in_t;

  // Expected controls packed as {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
  typedef struct {
    string      name;
    in_t        in;
    logic [6:0] exp_ctl;
  } vec_t;

  localparam logic [6:0] CTL_FROZEN = 7'b0000000;
  localparam logic [6:0] CTL_SQUASH = 7'b1111111;
  localparam logic [6:0] CTL_STALL  = 7'b0011101;
  localparam logic [6:0] CTL_RUN    = 7'b1111100;

  logic clk;
  logic rst;
  hazard_unit_if hif ();

  hazard_unit #(.MD_CYCLES(MD_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state: remaining busy cycles, pending done pulse, stall count
  int          m_left  = 0;
  bit          m_done  = 1'b0;
  logic [31:0] m_stall = '0;

  logic [6:0] last_act;
  logic       last_busy;
  logic       last_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt,
                             input logic use_rs, input logic use_rt,
                             input logic md_read, input logic mem_read,
                             input logic [4:0] ex_rt, input logic start,
                             input logic branch, input logic mstall);
    in_t v;
    v.id_rs = rs;              v.id_rt = rt;
    v.id_use_rs = use_rs;      v.id_use_rt = use_rt;
    v.id_md_read = md_read;    v.ex_mem_read = mem_read;
    v.ex_rt = ex_rt;           v.ex_md_start = start;
    v.ex_branch_taken = branch; v.mem_stall = mstall;
    return v;
  endfunction

  // Control outputs straight from the hazard rules.
  function automatic logic [6:0] ref_ctl(input in_t v, input bit busy, input logic rst_v);
    bit hazard;
    hazard = 1'b0;
    if (!rst_v || v.mem_stall) return CTL_FROZEN;
    if (v.ex_branch_taken) return CTL_SQUASH;
    if (v.ex_mem_read && v.ex_rt != 5'd0) begin
      if (v.id_use_rs && v.id_rs == v.ex_rt) hazard = 1'b1;
      if (v.id_use_rt && v.id_rt == v.ex_rt) hazard = 1'b1;
    end
    if (busy && v.id_md_read) hazard = 1'b1;
    return hazard ? CTL_STALL : CTL_RUN;
  endfunction

  task automatic drive(input in_t v);
    hif.id_rs           = v.id_rs;
    hif.id_rt           = v.id_rt;
    hif.id_use_rs       = v.id_use_rs;
    hif.id_use_rt       = v.id_use_rt;
    hif.id_md_read      = v.id_md_read;
    hif.ex_mem_read     = v.ex_mem_read;
    hif.ex_rt           = v.ex_rt;
    hif.ex_md_start     = v.ex_md_start;
    hif.ex_branch_taken = v.ex_branch_taken;
    hif.mem_stall       = v.mem_stall;
  endtask

  // One clock cycle: apply inputs and reset at the falling edge, compare just
  // after, then advance the model at the rising edge.
  task automatic run_cycle(input in_t v, input logic rst_v);
    logic [6:0] e;
    @(negedge clk);
    drive(v);
    rst = rst_v;
    #1;
    if (!rst_v) begin
      m_left  = 0;
      m_done  = 1'b0;
      m_stall = '0;
    end
    e = ref_ctl(v, m_left > 0, rst_v);
    last_act  = {hif.pc_we, hif.ifid_we, hif.idex_we, hif.exmem_we, hif.memwb_we,
                 hif.ifid_flush, hif.idex_flush};
    last_busy = hif.md_busy;
    last_done = hif.md_done;
    check("ctl", 64'(last_act), 64'(e));
    check("md_busy", 64'(last_busy), 64'(m_left > 0));
    check("md_done", 64'(last_done), 64'(m_done));
    check("stall_cycles", 64'(hif.stall_cycles), 64'(m_stall));
    @(posedge clk);
    if (rst_v) begin
      if (!e[6]) m_stall = m_stall + 32'd1;
      m_done = (m_left == 1);
      if (m_left > 0) m_left = m_left - 1;
      else if (v.ex_md_start && !v.mem_stall) m_left = MD_CYCLES;
    end
  endtask

  task automatic cyc(input in_t v);
    run_cycle(v, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[12];
    in_t  idle, start, lu, mdr, rv;
    logic [31:0] s0;
    int   busy_seen, pc_low_seen, done_seen;

    idle  = mk(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
    start = mk(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0, 0);
    lu    = mk(5'd8, 5'd3, 1, 1, 0, 1, 5'd8, 0, 0, 0);
    mdr   = mk(5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 0);

    tbl[0]  = '{"normal",          mk(5'd1, 5'd2, 1, 1, 0, 0, 5'd0, 0, 0, 0), CTL_RUN};
    tbl[1]  = '{"load_use_rs",     mk(5'd8, 5'd2, 1, 1, 0, 1, 5'd8, 0, 0, 0), CTL_STALL};
    tbl[2]  = '{"load_use_rt",     mk(5'd1, 5'd9, 1, 1, 0, 1, 5'd9, 0, 0, 0), CTL_STALL};
    tbl[3]  = '{"load_r0",         mk(5'd0, 5'd0, 1, 1, 0, 1, 5'd0, 0, 0, 0), CTL_RUN};
    tbl[4]  = '{"rs_not_used",     mk(5'd8, 5'd2, 0, 1, 0, 1, 5'd8, 0, 0, 0), CTL_RUN};
    tbl[5]  = '{"rt_not_used",     mk(5'd5, 5'd8, 1, 0, 0, 1, 5'd8, 0, 0, 0), CTL_RUN};
    tbl[6]  = '{"branch_over_lu",  mk(5'd8, 5'd2, 1, 1, 0, 1, 5'd8, 0, 1, 0), CTL_SQUASH};
    tbl[7]  = '{"mstall_over_lu",  mk(5'd8, 5'd2, 1, 1, 0, 1, 5'd8, 0, 0, 1), CTL_FROZEN};
    tbl[8]  = '{"mstall_over_br",  mk(5'd1, 5'd2, 1, 1, 0, 0, 5'd0, 0, 1, 1), CTL_FROZEN};
    tbl[9]  = '{"md_read_idle",    mk(5'd1, 5'd2, 1, 1, 1, 0, 5'd0, 0, 0, 0), CTL_RUN};
    tbl[10] = '{"no_load_match",   mk(5'd8, 5'd8, 1, 1, 0, 0, 5'd8, 0, 0, 0), CTL_RUN};
    tbl[11] = '{"both_match",      mk(5'd7, 5'd7, 1, 1, 0, 1, 5'd7, 0, 0, 0), CTL_STALL};

    // Reset state, then release
    drive(idle);
    rst = 1'b0;
    run_cycle(idle, 1'b0);
    run_cycle(idle, 1'b0);
    cyc(idle);
    check("after_reset_run", 64'(last_act), 64'(CTL_RUN));

    // Priority table
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].in);
      check(tbl[i].name, 64'(last_act), 64'(tbl[i].exp_ctl));
    end
    cyc(idle);

    // Load-use costs exactly one bubble
    s0 = m_stall;
    cyc(lu);
    cyc(idle);
    check("load_use_one_stall", 64'(hif.stall_cycles), 64'(s0 + 32'd1));

    // Multiply/divide with a dependent HI/LO reader held in ID
    busy_seen = 0; pc_low_seen = 0; done_seen = 0;
    s0 = m_stall;
    cyc(start);
    for (int k = 0; k < MD_CYCLES + 2; k++) begin
      cyc(mdr);
      if (last_busy) busy_seen++;
      if (!last_act[6]) pc_low_seen++;
      if (last_done) begin
        done_seen++;
        check("md_done_pc_we", 64'(last_act[6]), 64'(1));
      end
    end
    check("md_busy_cycles", 64'(busy_seen), 64'(MD_CYCLES));
    check("md_stall_cycles", 64'(pc_low_seen), 64'(MD_CYCLES));
    check("md_done_pulses", 64'(done_seen), 64'(1));
    check("md_stall_count", 64'(hif.stall_cycles), 64'(s0 + 32'(MD_CYCLES)));

    // Memory stall across the tail of an operation; start under stall refused
    cyc(start);
    cyc(idle);
    cyc(idle);
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(mk(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0, 1));
      if (last_done) done_seen = k + 1;
    end
    check("mstall_done_on_schedule", 64'(done_seen), 64'(3));
    cyc(idle);
    check("mstall_start_refused", 64'(last_busy), 64'(0));

    // Back-to-back operations: restart in the done cycle; starts while busy ignored
    cyc(start);
    for (int k = 0; k < MD_CYCLES + 2 && !m_done; k++) cyc(start);
    cyc(start);
    check("b2b_done_cycle", 64'(last_done), 64'(1));
    cyc(idle);
    check("b2b_restarted", 64'(last_busy), 64'(1));

    // Asynchronous reset in the middle of an operation
    cyc(lu);
    cyc(lu);
    run_cycle(idle, 1'b0);
    check("rst_mid_busy", 64'(last_busy), 64'(0));
    cyc(idle);

    // Counter wrap
    #2;
    force dut.stall_cycles_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cycles_q;
    m_stall = 32'hFFFF_FFFF;
    cyc(lu);
    cyc(idle);
    check("stall_wrap", 64'(hif.stall_cycles), 64'(0));

    // Randomized traffic with small register numbers to provoke conflicts
    for (int k = 0; k < 600; k++) begin
      rv = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0),
              1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0));
      run_cycle(rv, 1'($urandom_range(0, 99) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_hazard_unit

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage MIPS core. It drives the write-enable and flush inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline latches. It covers load-use stalls, taken-branch squashes and global memory stalls. It also sequences a fixed-latency multiply/divide unit and holds dependent HI/LO readers until the result is ready.

## Interface
- MD_CYCLES, 32: busy cycles of the multiply/divide unit per operation; legal range ≥ 2.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_use_rs  in  1  the ID instruction reads rs.
- id_use_rt  in  1  the ID instruction reads rt.
- id_md_read  in  1  the ID instruction is mfhi/mflo, mult or div.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_rt  in  5  destination register of the EX load.
- ex_md_start  in  1  the EX instruction is mult or div.
- ex_branch_taken  in  1  a branch or jump resolved taken in EX.
- mem_stall  in  1  memory system not ready; freezes the whole pipeline.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID latch write enable.
- idex_we  out  1  ID/EX latch write enable.
- exmem_we  out  1  EX/MEM latch write enable.
- memwb_we  out  1  MEM/WB latch write enable.
- ifid_flush  out  1  load a bubble (all zero) into IF/ID.
- idex_flush  out  1  load a bubble (all zero) into ID/EX.
- md_busy  out  1  multiply/divide operation in progress.
- md_done  out  1  one-cycle pulse: the HI/LO result is valid.
- stall_cycles  out  32  count of cycles with pc_we=0 outside reset; wraps.

## Operation
- State machine: IDLE and MD_BUSY, with a down-counter cnt of width clog2(MD_CYCLES). md_busy = (state==MD_BUSY).
- IDLE → MD_BUSY when ex_md_start=1 and mem_stall=0. On that transition cnt loads MD_CYCLES-1.
- In MD_BUSY, cnt decrements every cycle, independent of mem_stall. When cnt==0, the next state is IDLE and the registered md_done=1 for exactly that first IDLE cycle.
- ex_md_start while in MD_BUSY is ignored: no reload, no restart.
- load_use = ex_mem_read & (ex_rt≠0) & ((id_use_rs & id_rs==ex_rt) | (id_use_rt & id_rt==ex_rt)).
- md_hold = md_busy & id_md_read.
- Combinational outputs, evaluated in priority order:
  1. mem_stall=1: all *_we=0, both flushes=0.
  2. ex_branch_taken=1: all *_we=1, ifid_flush=1, idex_flush=1. The squashed ID instruction cannot cause a stall.
  3. load_use or md_hold: pc_we=0, ifid_we=0, idex_we=1, idex_flush=1, exmem_we=1, memwb_we=1, ifid_flush=0.
  4. Otherwise: all *_we=1, both flushes=0.
- A flush overrides the data path: the latch writes zero whenever its flush is 1.
- stall_cycles increments every cycle in which pc_we=0 and rst=1. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (rst=0, at any time, including mid MD_BUSY) forces, asynchronously: state=IDLE, cnt=0, md_done=0, stall_cycles=0, all *_we=0, both flushes=0.
- At the first edge after rst rises, the normal rules apply.
- Load-use costs exactly one bubble: the stall is asserted for one cycle, after which the load has moved to MEM and load_use drops.
- Multiply/divide latency:
  - ex_md_start is sampled at edge E0.
  - md_busy is high for cycles E0+1 … E0+MD_CYCLES.
  - md_done is high in cycle E0+MD_CYCLES+1, and md_busy=0 in that cycle.
- An id_md_read instruction is stalled through the last busy cycle and proceeds during the md_done cycle.
- A new ex_md_start is accepted during the md_done cycle (back-to-back operations).
- ex_md_start together with mem_stall=1 is not accepted; it is accepted on the first cycle with mem_stall=0.
- ex_branch_taken together with load_use: branch wins, no stall.
- mem_stall does not pause cnt, so md_done can occur while the pipeline is frozen.

## Test plan
- **Reset:** drive rst=0 mid-operation (md_busy=1, stall_cycles=5) → immediately md_busy=0, md_done=0, stall_cycles=0, all we=0; with rst=1 and no hazards → all we=1.
- **Load-use:** ex_mem_read=1, ex_rt=8, id_rs=8, id_use_rs=1 for one cycle → pc_we=0, ifid_we=0, idex_flush=1 for that cycle, stall_cycles=1 afterwards. Repeat with ex_rt=0 → no stall.
- **Branch vs load-use:** ex_branch_taken=1 with the load-use condition above → all we=1, ifid_flush=1, idex_flush=1, pc_we=1.
- **Multiply/divide:** MD_CYCLES=4, ex_md_start at E0, id_md_read=1 held → md_busy high for 4 cycles with pc_we=0, then md_done=1 for 1 cycle with pc_we=1; stall_cycles=4.
- **Memory stall:** mem_stall=1 for 3 cycles while in MD_BUSY with cnt=1 → all we=0; md_done still pulses on schedule; ex_md_start asserted during mem_stall is not accepted.
- **Counter wrap:** force stall_cycles=0xFFFFFFFF, then one stall cycle → stall_cycles=0.
